clk_switch_ctrl: RTL

Sequencer for the glitch-free N-way clock switch. It accepts source-change requests over a valid/ready handshake and drives the switch's `sel` bus. It holds off further changes until a programmable settle window has elapsed, and it rejects requests for sources flagged as failed. It runs on an always-on reference clock, sits beside the switch in the clock/reset subsystem, and optionally performs automatic failover when the active source fails.

---
 rtl/clk_switch_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: sequencer for a glitch-free N-way clock switch.
// Accepts source-change requests over a valid/ready handshake.
// Drives the switch select and then holds off further changes until a settle window expires.
// Rejects requests that target a source whose synchronized failure flag is set.
// Optional feature macro: CLK_SW_AUTO_FAILOVER_EN. When defined, the block moves off a
// failed active source on its own, to the lowest-index healthy source.
module clk_switch_ctrl #(
    parameter int CLK_NUM     = 4,
    parameter int SEL_W       = $clog2(CLK_NUM),
    parameter int DEFAULT_SEL = 0,
    parameter int SETTLE_CYC  = 16,
    parameter int CNT_W       = $clog2(SETTLE_CYC + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [SEL_W-1:0]   req_sel,
    output logic               req_ready,
    input  logic [CLK_NUM-1:0] clk_fail,
    output logic [SEL_W-1:0]   sel,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               failover,
    output logic               all_fail
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Select indices that address past the last real source read as failed.
    localparam int PAD_W = 1 << SEL_W;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] RESET_SEL   = SEL_W'(DEFAULT_SEL);

    state_t             state_q;
    logic [CLK_NUM-1:0] fail_meta_q;
    logic [CLK_NUM-1:0] fail_s_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   cur_sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               err_q;
    logic               all_fail_q;
    logic [PAD_W-1:0]   fail_pad;
    logic               all_fail_now;
    logic               fo_pend;

    // Two-flop synchronizer bringing the asynchronous failure flags into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_meta_q <= '0;
            fail_s_q    <= '0;
        end else begin
            fail_meta_q <= clk_fail;
            fail_s_q    <= fail_meta_q;
        end
    end

    // Failure vector widened to the full select range, with unused indices marked failed
    always_comb begin
        fail_pad              = '1;
        fail_pad[CLK_NUM-1:0] = fail_s_q;
    end

    assign all_fail_now = &fail_s_q;

`ifdef CLK_SW_AUTO_FAILOVER_EN
    logic             fo_q;
    logic [SEL_W-1:0] healthy_sel;

    // Lowest-index source whose synchronized failure flag is clear
    always_comb begin
        healthy_sel = '0;
        for (int i = CLK_NUM - 1; i >= 0; i--) begin
            if (!fail_s_q[i]) begin
                healthy_sel = SEL_W'(i);
            end
        end
    end

    // The same-cycle all-failed value is used so a failover never starts without a target
    assign fo_pend  = (state_q == IDLE) && fail_pad[cur_sel_q] && !all_fail_now;
    assign failover = fo_q;
`else
    assign fo_pend  = 1'b0;
    assign failover = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !fo_pend;
    assign busy      = (state_q == SETTLE);
    assign sel       = sel_q;
    assign cur_sel   = cur_sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign all_fail  = all_fail_q;

    // Request/settle sequencer; status pulses default low and at most one is raised per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= RESET_SEL;
            cur_sel_q  <= RESET_SEL;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            all_fail_q <= 1'b0;
`ifdef CLK_SW_AUTO_FAILOVER_EN
            fo_q       <= 1'b0;
`endif
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            all_fail_q <= all_fail_now;
`ifdef CLK_SW_AUTO_FAILOVER_EN
            fo_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
`ifdef CLK_SW_AUTO_FAILOVER_EN
                    if (fo_pend) begin
                        sel_q   <= healthy_sel;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= SETTLE;
                        fo_q    <= 1'b1;
                    end else
`endif
                    if (req_valid && req_ready) begin
                        if (fail_pad[req_sel]) begin
                            err_q <= 1'b1;
                        end else if (req_sel == cur_sel_q) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q   <= req_sel;
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        cur_sel_q <= sel_q;
                        state_q   <= IDLE;
                        if (fail_pad[sel_q]) begin
                            err_q <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
